// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the decode/execute boundary.
//   ALU_CTRL_W   : width of the ALU function select
//   STALL_CNT_W  : width of the stall-bubble counter
//   exec_fields_t: every field latched into the execute stage
//   EXEC_BUBBLE  : the value loaded on reset, stall, flush or an invalid slot
package pipeline_pkg;

    localparam int ALU_CTRL_W  = 4;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  alu_op;
        logic                  imm_op;
        logic                  mem_op;
        logic                  write_op;
        logic [4:0]            rs_addr;
        logic [4:0]            rt_addr;
        logic [4:0]            rd_addr;
        logic [31:0]           rs_data;
        logic [31:0]           rt_data;
        logic [31:0]           imm;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } exec_fields_t;

    // A bubble is an all-zero slot: invalid, no ops, register 0, zero data.
    localparam exec_fields_t EXEC_BUBBLE = '0;

endpackage

// File: rtl/operand_bypass_mux.sv
// Operand source select for one register operand.
//   addr_i      : register address; register 0 always reads as zero
//   me_bypass_i : take the memory-stage ALU result (highest priority)
//   we_bypass_i : take the writeback data
//   mresult_i   : memory-stage ALU result
//   wb_data_i   : writeback data
//   rf_data_i   : register-file read data (used when no bypass applies)
//   data_o      : selected operand
module operand_bypass_mux (
    input  logic [4:0]  addr_i,
    input  logic        me_bypass_i,
    input  logic        we_bypass_i,
    input  logic [31:0] mresult_i,
    input  logic [31:0] wb_data_i,
    input  logic [31:0] rf_data_i,
    output logic [31:0] data_o
);

    // The newer result (memory stage) wins over the older one (writeback).
    always_comb begin
        data_o = rf_data_i;
        if (addr_i == 5'd0) begin
            data_o = 32'd0;
        end else if (me_bypass_i) begin
            data_o = mresult_i;
        end else if (we_bypass_i) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/decode_exec_stage.sv
// Decode-to-execute pipeline register with operand bypassing.
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   w_stall, w_flush        : hazard stall and branch squash of the decode slot
//   w_d*                    : decode-stage instruction fields
//   w_me_*/w_we_* bypass    : operand forwarding selects
//   w_mresult_32/w_wb_data_32: forwarding sources
//   w_e*                    : registered execute-stage fields
//   w_dhold                 : hold enable for upstream fetch/decode registers
//   w_stall_cnt_16          : saturating count of stall bubbles
//
// Pipeline control: a decode slot advances on every edge unless w_stall or
// w_flush is high. Flush discards the slot (bubble, no hold). Stall inserts a
// bubble and raises w_dhold so decode keeps the same instruction; it enters
// execute on the first unstalled edge with bypasses evaluated on that edge.
module decode_exec_stage
    import pipeline_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   w_stall,
    input  logic                   w_flush,
    input  logic                   w_dvalid,
    input  logic                   w_dalu_op,
    input  logic                   w_dimm_op,
    input  logic                   w_dmem_op,
    input  logic                   w_dwrite_op,
    input  logic [4:0]             w_drs_addr_5,
    input  logic [4:0]             w_drt_addr_5,
    input  logic [4:0]             w_drd_addr_5,
    input  logic [31:0]            w_drs_data_32,
    input  logic [31:0]            w_drt_data_32,
    input  logic [31:0]            w_dimm_32,
    input  logic [ALU_CTRL_W-1:0]  w_dalu_ctrl_4,
    input  logic                   w_me_rs_bypass,
    input  logic                   w_me_rt_bypass,
    input  logic                   w_we_rs_bypass,
    input  logic                   w_we_rt_bypass,
    input  logic [31:0]            w_mresult_32,
    input  logic [31:0]            w_wb_data_32,
    output logic                   w_evalid,
    output logic                   w_ealu_op,
    output logic                   w_eimm_op,
    output logic                   w_emem_op,
    output logic                   w_ewrite_op,
    output logic [4:0]             w_ers_addr_5,
    output logic [4:0]             w_ert_addr_5,
    output logic [4:0]             w_erd_addr_5,
    output logic [31:0]            w_ers_data_32,
    output logic [31:0]            w_ert_data_32,
    output logic [31:0]            w_eimm_32,
    output logic [ALU_CTRL_W-1:0]  w_ealu_ctrl_4,
    output logic                   w_dhold,
    output logic [STALL_CNT_W-1:0] w_stall_cnt_16
);

    exec_fields_t           ex_q, ex_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]            rs_sel, rt_sel;
    logic                   stall_bubble;

    operand_bypass_mux u_rs_mux (
        .addr_i      (w_drs_addr_5),
        .me_bypass_i (w_me_rs_bypass),
        .we_bypass_i (w_we_rs_bypass),
        .mresult_i   (w_mresult_32),
        .wb_data_i   (w_wb_data_32),
        .rf_data_i   (w_drs_data_32),
        .data_o      (rs_sel)
    );

    operand_bypass_mux u_rt_mux (
        .addr_i      (w_drt_addr_5),
        .me_bypass_i (w_me_rt_bypass),
        .we_bypass_i (w_we_rt_bypass),
        .mresult_i   (w_mresult_32),
        .wb_data_i   (w_wb_data_32),
        .rf_data_i   (w_drt_data_32),
        .data_o      (rt_sel)
    );

    // Stall only counts when flush is not squashing the slot anyway.
    assign stall_bubble = w_stall & ~w_flush;

    // Reset is synchronous, but hold must already be low while it is asserted.
    assign w_dhold = reset_n & stall_bubble;

    always_comb begin
        ex_d        = EXEC_BUBBLE;
        stall_cnt_d = stall_cnt_q;
        if (!w_flush && !w_stall && w_dvalid) begin
            ex_d.valid    = 1'b1;
            ex_d.alu_op   = w_dalu_op;
            ex_d.imm_op   = w_dimm_op;
            ex_d.mem_op   = w_dmem_op;
            ex_d.write_op = w_dwrite_op;
            ex_d.rs_addr  = w_drs_addr_5;
            ex_d.rt_addr  = w_drt_addr_5;
            ex_d.rd_addr  = w_drd_addr_5;
            ex_d.rs_data  = rs_sel;
            ex_d.rt_data  = rt_sel;
            ex_d.imm      = w_dimm_32;
            ex_d.alu_ctrl = w_dalu_ctrl_4;
        end
        if (stall_bubble && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ex_q        <= EXEC_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign w_evalid       = ex_q.valid;
    assign w_ealu_op      = ex_q.alu_op;
    assign w_eimm_op      = ex_q.imm_op;
    assign w_emem_op      = ex_q.mem_op;
    assign w_ewrite_op    = ex_q.write_op;
    assign w_ers_addr_5   = ex_q.rs_addr;
    assign w_ert_addr_5   = ex_q.rt_addr;
    assign w_erd_addr_5   = ex_q.rd_addr;
    assign w_ers_data_32  = ex_q.rs_data;
    assign w_ert_data_32  = ex_q.rt_data;
    assign w_eimm_32      = ex_q.imm;
    assign w_ealu_ctrl_4  = ex_q.alu_ctrl;
    assign w_stall_cnt_16 = stall_cnt_q;

endmodule

// File: tb/tb_decode_exec_stage.sv
// Directed bench for decode_exec_stage: capture, bypass priority, zero
// register, invalid slot, multi-cycle stall, stall+flush, flush-only,
// counter saturation and reset during a stall.
module tb_decode_exec_stage;

    logic        clock;
    logic        reset_n;
    logic        w_stall, w_flush;
    logic        w_dvalid, w_dalu_op, w_dimm_op, w_dmem_op, w_dwrite_op;
    logic [4:0]  w_drs_addr_5, w_drt_addr_5, w_drd_addr_5;
    logic [31:0] w_drs_data_32, w_drt_data_32, w_dimm_32;
    logic [3:0]  w_dalu_ctrl_4;
    logic        w_me_rs_bypass, w_me_rt_bypass, w_we_rs_bypass, w_we_rt_bypass;
    logic [31:0] w_mresult_32, w_wb_data_32;
    logic        w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op;
    logic [4:0]  w_ers_addr_5, w_ert_addr_5, w_erd_addr_5;
    logic [31:0] w_ers_data_32, w_ert_data_32, w_eimm_32;
    logic [3:0]  w_ealu_ctrl_4;
    logic        w_dhold;
    logic [15:0] w_stall_cnt_16;

    int checks   = 0;
    int failures = 0;

    decode_exec_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .w_stall        (w_stall),
        .w_flush        (w_flush),
        .w_dvalid       (w_dvalid),
        .w_dalu_op      (w_dalu_op),
        .w_dimm_op      (w_dimm_op),
        .w_dmem_op      (w_dmem_op),
        .w_dwrite_op    (w_dwrite_op),
        .w_drs_addr_5   (w_drs_addr_5),
        .w_drt_addr_5   (w_drt_addr_5),
        .w_drd_addr_5   (w_drd_addr_5),
        .w_drs_data_32  (w_drs_data_32),
        .w_drt_data_32  (w_drt_data_32),
        .w_dimm_32      (w_dimm_32),
        .w_dalu_ctrl_4  (w_dalu_ctrl_4),
        .w_me_rs_bypass (w_me_rs_bypass),
        .w_me_rt_bypass (w_me_rt_bypass),
        .w_we_rs_bypass (w_we_rs_bypass),
        .w_we_rt_bypass (w_we_rt_bypass),
        .w_mresult_32   (w_mresult_32),
        .w_wb_data_32   (w_wb_data_32),
        .w_evalid       (w_evalid),
        .w_ealu_op      (w_ealu_op),
        .w_eimm_op      (w_eimm_op),
        .w_emem_op      (w_emem_op),
        .w_ewrite_op    (w_ewrite_op),
        .w_ers_addr_5   (w_ers_addr_5),
        .w_ert_addr_5   (w_ert_addr_5),
        .w_erd_addr_5   (w_erd_addr_5),
        .w_ers_data_32  (w_ers_data_32),
        .w_ert_data_32  (w_ert_data_32),
        .w_eimm_32      (w_eimm_32),
        .w_ealu_ctrl_4  (w_ealu_ctrl_4),
        .w_dhold        (w_dhold),
        .w_stall_cnt_16 (w_stall_cnt_16)
    );

    // Clock / reset generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // All execute outputs packed together; a bubble is all zero.
    logic [119:0] ex_all;
    assign ex_all = {w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op,
                     w_ers_addr_5, w_ert_addr_5, w_erd_addr_5,
                     w_ers_data_32, w_ert_data_32, w_eimm_32, w_ealu_ctrl_4};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_instr(input logic [4:0] rs, input logic [31:0] rs_d,
                               input logic [4:0] rt, input logic [31:0] rt_d);
        w_dvalid      = 1'b1;
        w_dalu_op     = 1'b1;
        w_dimm_op     = 1'b0;
        w_dmem_op     = 1'b1;
        w_dwrite_op   = 1'b1;
        w_drs_addr_5  = rs;
        w_drs_data_32 = rs_d;
        w_drt_addr_5  = rt;
        w_drt_data_32 = rt_d;
        w_drd_addr_5  = 5'd5;
        w_dimm_32     = 32'h0000_1234;
        w_dalu_ctrl_4 = 4'hA;
    endtask

    task automatic clear_bypass();
        w_me_rs_bypass = 1'b0;
        w_me_rt_bypass = 1'b0;
        w_we_rs_bypass = 1'b0;
        w_we_rt_bypass = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; w_stall = 1'b0; w_flush = 1'b0;
        w_dvalid = 1'b0; w_dalu_op = 1'b0; w_dimm_op = 1'b0; w_dmem_op = 1'b0; w_dwrite_op = 1'b0;
        w_drs_addr_5 = '0; w_drt_addr_5 = '0; w_drd_addr_5 = '0;
        w_drs_data_32 = '0; w_drt_data_32 = '0; w_dimm_32 = '0; w_dalu_ctrl_4 = '0;
        clear_bypass();
        w_mresult_32 = '0; w_wb_data_32 = '0;

        // Reset state, with a stall held during reset
        step();
        step();
        check("reset_bubble", ex_all, 0);
        check("reset_cnt", w_stall_cnt_16, 0);
        w_stall = 1'b1;
        #1;
        check("reset_dhold_low", w_dhold, 0);
        w_stall = 1'b0;

        // Plain capture on the first edge after reset release
        reset_n = 1'b1;
        drive_instr(5'd3, 32'h11, 5'd4, 32'h22);
        step();
        check("cap_valid", w_evalid, 1);
        check("cap_rs_data", w_ers_data_32, 32'h11);
        check("cap_rt_data", w_ert_data_32, 32'h22);
        check("cap_fields", {w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op, w_ers_addr_5,
                             w_ert_addr_5, w_erd_addr_5, w_eimm_32, w_ealu_ctrl_4},
              {4'b1011, 5'd3, 5'd4, 5'd5, 32'h1234, 4'hA});

        // Bypass priority: memory stage over writeback
        w_me_rs_bypass = 1'b1; w_we_rs_bypass = 1'b1;
        w_mresult_32 = 32'hAAAA; w_wb_data_32 = 32'h5555;
        step();
        check("byp_me_over_we", w_ers_data_32, 32'hAAAA);
        check("byp_rt_untouched", w_ert_data_32, 32'h22);
        w_me_rs_bypass = 1'b0; w_we_rt_bypass = 1'b1;
        step();
        check("byp_we_rs", w_ers_data_32, 32'h5555);
        check("byp_we_rt", w_ert_data_32, 32'h5555);
        clear_bypass();

        // Zero register ignores bypass
        drive_instr(5'd3, 32'h11, 5'd0, 32'h99);
        w_me_rt_bypass = 1'b1; w_mresult_32 = 32'hFFFF;
        step();
        check("zero_reg_rt", w_ert_data_32, 0);
        check("zero_reg_rs", w_ers_data_32, 32'h11);
        clear_bypass();

        // Invalid decode slot becomes a bubble
        w_dvalid = 1'b0;
        step();
        check("invalid_bubble", ex_all, 0);
        check("invalid_no_count", w_stall_cnt_16, 0);

        // Three-cycle stall, then the held instruction enters
        drive_instr(5'd7, 32'h77, 5'd8, 32'h88);
        w_stall = 1'b1;
        #1;
        check("stall_dhold", w_dhold, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("stall_bubble_%0d", i), ex_all, 0);
            check($sformatf("stall_cnt_%0d", i), w_stall_cnt_16, i);
            check($sformatf("stall_dhold_%0d", i), w_dhold, 1);
        end
        // Bypass changes just before release must be seen at the release edge
        w_stall = 1'b0;
        w_me_rs_bypass = 1'b1; w_mresult_32 = 32'hBEEF;
        #1;
        check("release_dhold", w_dhold, 0);
        step();
        check("release_valid", w_evalid, 1);
        check("release_rs_data", w_ers_data_32, 32'hBEEF);
        check("release_rt_data", w_ert_data_32, 32'h88);
        check("release_cnt", w_stall_cnt_16, 3);
        clear_bypass();

        // Stall and flush together: flush wins, no hold, no count
        w_stall = 1'b1; w_flush = 1'b1;
        #1;
        check("sf_dhold", w_dhold, 0);
        step();
        check("sf_bubble", ex_all, 0);
        check("sf_cnt", w_stall_cnt_16, 3);

        // Flush only
        w_stall = 1'b0;
        step();
        check("flush_bubble", ex_all, 0);
        check("flush_cnt", w_stall_cnt_16, 3);
        w_flush = 1'b0;

        // Saturation: stall until the counter reaches 0xFFFF, then once more
        w_stall = 1'b1;
        repeat (65532) @(posedge clock);
        #1;
        check("sat_reach", w_stall_cnt_16, 16'hFFFF);
        step();
        check("sat_hold", w_stall_cnt_16, 16'hFFFF);
        check("sat_bubble", ex_all, 0);

        // Reset in the middle of a stall
        reset_n = 1'b0;
        #1;
        check("rst_mid_dhold", w_dhold, 0);
        step();
        check("rst_mid_bubble", ex_all, 0);
        check("rst_mid_cnt", w_stall_cnt_16, 0);

        // Normal capture right after reset release
        reset_n = 1'b1; w_stall = 1'b0;
        drive_instr(5'd2, 32'h42, 5'd6, 32'h66);
        step();
        check("post_rst_valid", w_evalid, 1);
        check("post_rst_rs", w_ers_data_32, 32'h42);
        check("post_rst_cnt", w_stall_cnt_16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
